serial_adder_n: RTL and testbench

//  Parametrised multi-cycle adder/subtractor, successor to the 1-bit gate-level half adder.

---
 rtl/serial_adder_n_pkg.sv | 14 +
 rtl/fa_bit.sv | 18 +
 rtl/serial_adder_n.sv | 134 +++++++++++++
 tb/tb_serial_adder_n.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_n_pkg.sv
// Shared types and helpers for the serial adder/subtractor.
package serial_adder_n_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Step counter needs at least one bit even for a single-step configuration.
  function automatic int cnt_width(input int steps);
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/fa_bit.sv
// Gate-level full adder built from two half-adder stages and an OR.
module fa_bit (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic ci
);

  logic s1, c1, c2;

  assign s1   = a ^ b;
  assign c1   = a & b;
  assign sum  = s1 ^ ci;
  assign c2   = s1 & ci;
  assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder_n.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock through a ripple of fa_bit cells.
// Outputs are registered at completion and held until the next completed operation.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// RUN   | consuming operand slices LSB-first, one slice per clock
module serial_adder_n #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  import serial_adder_n_pkg::*;

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = cnt_width(STEPS);

  if (WIDTH < 2 || BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > WIDTH ||
      (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
    $error("serial_adder_n: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
  end

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]        a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]        res_q, res_d, res_next;
  logic [WIDTH-1:0]        sum_q, sum_d;
  logic                    carry_q, carry_d;
  logic                    cout_q, cout_d;
  logic                    ovf_q, ovf_d;
  logic                    done_q, done_d;
  logic [BITS_PER_CYCLE:0] c_chain;
  logic [BITS_PER_CYCLE-1:0] slice;

  assign c_chain[0] = carry_q;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_fa
    fa_bit u_fa (
      .sum  (slice[gi]),
      .cout (c_chain[gi+1]),
      .a    (a_q[gi]),
      .b    (b_q[gi]),
      .ci   (c_chain[gi])
    );
  end

  // New slice enters from the MSB side, so after STEPS shifts bit 0 lands in place.
  assign res_next = WIDTH'({slice, res_q} >> BITS_PER_CYCLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub | cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> BITS_PER_CYCLE;
        b_d     = b_q >> BITS_PER_CYCLE;
        res_d   = res_next;
        carry_d = c_chain[BITS_PER_CYCLE];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) begin
          sum_d   = res_next;
          cout_d  = c_chain[BITS_PER_CYCLE];
          ovf_d   = c_chain[BITS_PER_CYCLE] ^ c_chain[BITS_PER_CYCLE-1];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: one-bit and four-bit-per-cycle instances against an arithmetic model.
module tb_serial_adder_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, sub, cin;
  logic [7:0] a, b;

  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum4;

  int checks = 0;
  int errors = 0;

  serial_adder_n #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
  );

  serial_adder_n #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {cout, overflow, sum} from plain two's-complement arithmetic.
  function automatic logic [9:0] model_op(input logic [7:0] ia, input logic [7:0] ib,
                                          input logic isub, input logic icin);
    logic [7:0] bb;
    logic [8:0] full;
    logic       ov;
    bb   = isub ? ~ib : ib;
    full = {1'b0, ia} + {1'b0, bb} + {8'b0, (isub | icin)};
    ov   = (ia[7] == bb[7]) && (full[7] != ia[7]);
    return {full[8], ov, full[7:0]};
  endfunction

  function automatic int steps_of(input int i);
    return (i == 0) ? 8 : 2;
  endfunction

  logic       m_busy [2];
  logic       m_done [2];
  logic [9:0] m_res  [2];
  logic [9:0] m_pend [2];
  int         m_rem  [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_res[i]  <= '0;
        m_pend[i] <= '0;
        m_rem[i]  <= 0;
      end else begin
        m_done[i] <= 1'b0;
        if (!m_busy[i]) begin
          if (start) begin
            m_busy[i] <= 1'b1;
            m_rem[i]  <= steps_of(i);
            m_pend[i] <= model_op(a, b, sub, cin);
          end
        end else begin
          m_rem[i] <= m_rem[i] - 1;
          if (m_rem[i] == 1) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
            m_res[i]  <= m_pend[i];
          end
        end
      end
    end
  end

  task automatic cmp_dut(input string tag, input int i, input logic bz, input logic dn,
                         input logic [7:0] sm, input logic co, input logic ov);
    chk({tag, "_busy"}, bz, m_busy[i]);
    chk({tag, "_done"}, dn, m_done[i]);
    chk({tag, "_sum"},  sm, m_res[i][7:0]);
    chk({tag, "_cout"}, co, m_res[i][9]);
    chk({tag, "_ovf"},  ov, m_res[i][8]);
  endtask

  always @(negedge clk) begin
    cmp_dut("d1", 0, busy1, done1, sum1, cout1, ovf1);
    cmp_dut("d4", 1, busy4, done4, sum4, cout4, ovf4);
  end

  task automatic op(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                    input logic icin, input logic [7:0] es, input logic ec, input logic eo);
    int n, n4;
    bit seen;
    @(negedge clk);
    a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~ia; b = ~ib; sub = ~isub; cin = ~icin;
    n = 0; n4 = 0; seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (done4 && n4 == 0) n4 = k;
      if (done1) begin
        n = k;
        seen = 1'b1;
      end
    end
    chk("op_done_seen", seen, 1);
    chk("op_lat1", n, 8);
    chk("op_lat4", n4, 2);
    chk("op_sum1", sum1, es);
    chk("op_cout1", cout1, ec);
    chk("op_ovf1", ovf1, eo);
    chk("op_sum4", sum4, es);
    chk("op_cout4", cout4, ec);
    chk("op_ovf4", ovf4, eo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = ~start; sub = ~sub; cin = $urandom_range(1, 0) == 1;
      a = 8'($urandom); b = 8'($urandom);
      #1;
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_sum",  sum1, 0);
      chk("rst_ovf4", ovf4, 0);
    end
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;

    op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op(8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
    op(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    op(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // start held high across several operations: re-accept on the cycle after done
    @(negedge clk);
    a = 8'h03; b = 8'h04; sub = 1'b0; cin = 1'b0; start = 1'b1;
    repeat (30) @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("b2b_sum1", sum1, 8'h07);
    chk("b2b_sum4", sum4, 8'h07);

    @(negedge clk);
    a = 8'h5A; b = 8'h3C; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_busy1", busy1, 0);
    chk("midrst_done1", done1, 0);
    chk("midrst_sum1",  sum1, 0);
    chk("midrst_sum4",  sum4, 0);
    chk("midrst_ovf4",  ovf4, 0);
    chk("midrst_done4", done4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_nodone_sum1", sum1, 0);
    op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
